pipe_shifter: RTL

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_stage.sv | 101 ++++++++++
 rtl/pipe_shifter.sv | 78 +++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared op codes and elaboration-time helpers for the pipelined barrel shifter.
// Also computes how the mux levels are spread over the pipeline stages.
package shift_pkg;

    localparam logic [2:0] OP_LSL  = 3'b000;
    localparam logic [2:0] OP_LSR  = 3'b001;
    localparam logic [2:0] OP_ASR  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;

    function automatic int clog2(input int value);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= value) return r;
        end
        return 31;
    endfunction

    // Levels owned by stage s; any remainder goes to the earliest stages.
    function automatic int levels_in_stage(input int total, input int stages, input int s);
        return (total / stages) + ((s < (total % stages)) ? 1 : 0);
    endfunction

    function automatic int first_level(input int total, input int stages, input int s);
        return (s * (total / stages)) + ((s < (total % stages)) ? s : (total % stages));
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One register boundary of the shifter: a few binary mux levels, the carry they
// produce, and the valid/op/amount sideband, all held while the pipe is stalled.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AW        = clog2(WIDTH),
    parameter int FIRST_LVL = 0,
    parameter int NUM_LVL   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic             i_err,
    input  logic             i_carry,
    input  logic [2:0]       i_op,
    input  logic [AW-1:0]    i_amt,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_err,
    output logic             o_carry,
    output logic [2:0]       o_op,
    output logic [AW-1:0]    o_amt,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_out_bit;
    logic [AW-1:0]    w_amt_sh;
    logic             w_carry;
    int               w_sh;

    // NOTE: blocking assignments here chain each level's output into the next
    // level within the same evaluation; every variable gets a default first so
    // no latch is inferred.
    always_comb begin
        w_data    = i_data;
        w_carry   = i_carry;
        w_out_bit = '0;
        w_amt_sh  = '0;
        w_sh      = 0;
        if (!i_err && (i_op != OP_PASS)) begin
            for (int k = 0; k < NUM_LVL; k++) begin
                w_sh     = 1 << (FIRST_LVL + k);
                w_amt_sh = i_amt >> (FIRST_LVL + k);
                if (w_amt_sh[0]) begin
                    // The last level that actually moves bits decides the carry.
                    if ((i_op == OP_LSL) || (i_op == OP_ROL))
                        w_out_bit = w_data >> (WIDTH - w_sh);
                    else
                        w_out_bit = w_data >> (w_sh - 1);
                    w_carry = w_out_bit[0];
                    case (i_op)
                        OP_LSL:  w_data = w_data << w_sh;
                        OP_LSR:  w_data = w_data >> w_sh;
                        OP_ASR:  w_data = $unsigned($signed(w_data) >>> w_sh);
                        OP_ROR:  w_data = (w_data >> w_sh) | (w_data << (WIDTH - w_sh));
                        OP_ROL:  w_data = (w_data << w_sh) | (w_data >> (WIDTH - w_sh));
                        default: w_data = w_data;
                    endcase
                end
            end
        end
    end

    logic             r_valid;
    logic             r_err;
    logic             r_carry;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_amt;
    logic [WIDTH-1:0] r_data;

    // NOTE: non-blocking assignments for all state; the data registers are
    // reset too because the reset value of out_data is part of the interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_carry <= 1'b0;
            r_op    <= '0;
            r_amt   <= '0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_err   <= i_err;
            r_carry <= w_carry;
            r_op    <= i_op;
            r_amt   <= i_amt;
            r_data  <= w_data;
        end
    end

    assign o_valid = r_valid;
    assign o_err   = r_err;
    assign o_carry = r_carry;
    assign o_op    = r_op;
    assign o_amt   = r_amt;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready handshake and a global stall.
// Mux levels are split across STAGES shift_stage instances.
module pipe_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    input  logic [clog2(WIDTH)-1:0] in_amt,
    input  logic [2:0]              in_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_carry,
    output logic                    out_zero,
    output logic                    out_err
);

    localparam int AW = clog2(WIDTH);

    logic             w_en;
    logic             w_valid [STAGES+1];
    logic             w_err   [STAGES+1];
    logic             w_carry [STAGES+1];
    logic [2:0]       w_op    [STAGES+1];
    logic [AW-1:0]    w_amt   [STAGES+1];
    logic [WIDTH-1:0] w_data  [STAGES+1];

    // A full output that is not being taken freezes every stage at once,
    // so bubbles keep their place.
    assign in_ready = !(out_valid && !out_ready);
    assign w_en     = in_ready;

    // Illegal op codes enter the pipe as a zero operand flagged as an error.
    assign w_valid[0] = in_valid;
    assign w_err[0]   = (in_op > OP_PASS);
    assign w_carry[0] = 1'b0;
    assign w_op[0]    = in_op;
    assign w_amt[0]   = in_amt;
    assign w_data[0]  = (in_op > OP_PASS) ? '0 : in_data;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .WIDTH     (WIDTH),
            .AW        (AW),
            .FIRST_LVL (first_level(AW, STAGES, s)),
            .NUM_LVL   (levels_in_stage(AW, STAGES, s))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_en),
            .i_valid (w_valid[s]),
            .i_err   (w_err[s]),
            .i_carry (w_carry[s]),
            .i_op    (w_op[s]),
            .i_amt   (w_amt[s]),
            .i_data  (w_data[s]),
            .o_valid (w_valid[s+1]),
            .o_err   (w_err[s+1]),
            .o_carry (w_carry[s+1]),
            .o_op    (w_op[s+1]),
            .o_amt   (w_amt[s+1]),
            .o_data  (w_data[s+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign out_data  = w_data[STAGES];
    assign out_carry = w_carry[STAGES];
    assign out_err   = w_err[STAGES];
    assign out_zero  = w_valid[STAGES] && (w_data[STAGES] == '0);

endmodule
